fp_norm: RTL
============

FP_NORM -- requirements
Module: fp_norm

Interface
REQ-001 SHALL have parameter ORDER, default 3, mantissa input width W = 2**ORDER.
REQ-002 SHALL have parameter OW, default 5, output mantissa width including the leading one; OW < W.
REQ-003 SHALL have parameter EW, default 6, biased exponent width; all-ones exponent is reserved for overflow/infinity.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 in_valid  in  1  input word valid; in_ready  out  1  stage can accept.
REQ-007 in_s  in  1  sign; in_e  in  EW  biased exponent; in_m  in  W  unsigned unnormalized magnitude.
REQ-008 out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-009 out_s  out  1; out_e  out  EW; out_m  out  OW  normalized mantissa, MSB = 1 unless zero or flush.
REQ-010 out_zero, out_uf, out_of, out_nx  out  1 each  zero-input, underflow-flush, overflow, inexact flags.

Function
REQ-011 Transfer occurs on a rising edge where valid and ready are both 1 on that port.
REQ-012 Two register stages, S1 and S2, each with its own valid bit; latency is exactly 2 cycles from input transfer to out_valid with no stall.
REQ-013 S1 registers s, e, aligned mantissa (in_m << clz) and count = clz(in_m), width ORDER+1, where in_m = 0 gives count = W.
REQ-014 S2 registers rounded result; S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S2 loads.
REQ-015 in_ready = ~S1.valid | S2-load condition; no combinational path from in_valid to in_ready.
REQ-016 Full throughput: one word per cycle with out_ready held 1.
REQ-017 Stall: with out_ready=0, output registers and flags hold stable; no word is lost or duplicated.
REQ-018 Rounding input: kept = top OW bits of aligned mantissa; guard = next bit; sticky = OR of remaining bits.
REQ-019 Round-to-nearest-even: increment kept when guard & (sticky | kept[0]).
REQ-020 Carry out of increment: mantissa becomes 1 followed by zeros; exponent +1.
REQ-021 out_nx = guard | sticky for non-zero, non-flushed inputs.
REQ-022 Exponent: e' = in_e - count, plus 1 on round carry, computed at EW+1 bits signed.
REQ-023 Zero input (in_m = 0): out_e = 0, out_m = 0, out_zero = 1, other flags 0, sign passed through.
REQ-024 Underflow (in_e <= count, non-zero in_m): out_e = 0, out_m = 0, out_uf = 1, out_nx = 1.
REQ-025 Overflow (final e' >= 2**EW-1): out_e all-ones, out_m = 0, out_of = 1, out_nx = 1.
REQ-026 At most one of out_zero/out_uf/out_of is set per word.

Reset
REQ-027 While rst_n=0: S1/S2 valid = 0, out_valid = 0, in_ready = 0; data outputs and flags = 0.
REQ-028 Reset mid-operation discards all in-flight words; first cycle after release in_ready = 1.

Configuration
REQ-029 FP_NORM_ROUND_EN defined: rounding per REQ-019/020.
REQ-030 FP_NORM_ROUND_EN undefined: truncation (kept bits unchanged, no carry path); out_nx still reports guard | sticky; latency unchanged.

Structure
REQ-031 Shared include holds flag bit positions and the overflow-exponent constant; guarded against double inclusion.
REQ-032 Leading-zero count and shift use one instance of the existing serial align module (align_s, ORDER, W) in S1; no other sub-module.

Verification (ORDER=3, OW=5, EW=6)
REQ-033 m=0001_0110, e=20, out_ready=1 -> 2 cycles later out_m=10110, out_e=17, all flags 0.
REQ-034 m=1111_1100, e=10 -> tie with odd lsb, round carry: out_m=10000, out_e=11, out_nx=1 (truncate build: out_m=11111, out_e=10, nx=1).
REQ-035 m=0000_0001, e=5 -> count 7 >= 5: out_e=0, out_m=0, out_uf=1; m=0, e=9 -> out_zero=1, out_e=0.
REQ-036 m=1111_1111, e=62 -> carry to 63: out_e=63, out_m=0, out_of=1.
REQ-037 Back-to-back 8 words with out_ready toggling 1,0,0,1,... -> outputs in order, stable while stalled, in_ready=0 only when both stages full and out_ready=0.
REQ-038 Assert rst_n low with both stages valid -> out_valid=0 immediately; after release, next input appears 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - flag indices and result classes shared by fp_norm
`include "fp_norm_defs.sv"

package fp_norm_pkg;

  localparam int FLAG_ZERO = `FP_NORM_FLAG_ZERO;
  localparam int FLAG_UF   = `FP_NORM_FLAG_UF;
  localparam int FLAG_OF   = `FP_NORM_FLAG_OF;
  localparam int FLAG_NX   = `FP_NORM_FLAG_NX;
  localparam int NFLAGS    = `FP_NORM_NFLAGS;

  // Outcome of one word; at most one special class applies
  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_UF,
    CLS_OF
  } cls_e;

endpackage

// File: rtl/fp_norm_align.sv
// rtl/fp_norm_align.sv - align_s: log-step leading-zero count and left shift
module align_s
  import fp_norm_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int W     = 8
) (
  input  logic [W-1:0]   m_i,
  output logic [W-1:0]   m_o,
  output logic [ORDER:0] cnt_o
);

  // stage[ORDER] is the raw input; each step closes a gap of 2**k zeros
  logic [W-1:0]     stage [0:ORDER];
  logic [ORDER-1:0] zbit;

  assign stage[ORDER] = m_i;

  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign zbit[k]  = ~|stage[k+1][W-1 -: SH];
    assign stage[k] = zbit[k] ? (stage[k+1] << SH) : stage[k+1];
  end

  assign m_o = stage[0];
  // An all-zero word walks through every step and still has no leading one
  assign cnt_o = stage[0][W-1] ? {1'b0, zbit} : (ORDER+1)'(W);

endmodule

// File: rtl/fp_norm_defs.sv
// rtl/fp_norm_defs.sv - shared flag bit positions and overflow exponent constant
`ifndef FP_NORM_DEFS_SV
`define FP_NORM_DEFS_SV

`define FP_NORM_FLAG_ZERO 0
`define FP_NORM_FLAG_UF   1
`define FP_NORM_FLAG_OF   2
`define FP_NORM_FLAG_NX   3
`define FP_NORM_NFLAGS    4

// Exponent reserved for overflow/infinity: all ones at the given width
`define FP_NORM_OF_EXP(ew) {(ew){1'b1}}

`endif

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - two-stage normalize/round pipeline; FP_NORM_ROUND_EN selects round-to-nearest-even over truncation
module fp_norm
  import fp_norm_pkg::*;
#(
  parameter int  ORDER = 3,
  parameter int  OW    = 5,
  parameter int  EW    = 6,
  localparam int W     = 1 << ORDER
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_s,
  input  logic [EW-1:0] in_e,
  input  logic [W-1:0]  in_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [OW-1:0] out_m,
  output logic          out_zero,
  output logic          out_uf,
  output logic          out_of,
  output logic          out_nx
);

  logic              s1_valid_q, s1_s_q;
  logic [EW-1:0]     s1_e_q;
  logic [W-1:0]      s1_m_q;
  logic [ORDER:0]    s1_cnt_q;
  logic [W-1:0]      algn_m;
  logic [ORDER:0]    algn_cnt;
  logic              s1_load, s2_load;
  logic              s2_valid_q, s2_s_q;
  logic [EW-1:0]     s2_e_q, s2_e_d;
  logic [OW-1:0]     s2_m_q, s2_m_d;
  logic [NFLAGS-1:0] s2_flags_q, s2_flags_d;

  // Handshake depends only on registered valids and out_ready
  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = rst_n & s1_load;

  align_s #(.ORDER(ORDER), .W(W)) u_align (
    .m_i   (in_m),
    .m_o   (algn_m),
    .cnt_o (algn_cnt)
  );

  // S1: capture sign, exponent, aligned mantissa and its shift count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_e_q     <= '0;
      s1_m_q     <= '0;
      s1_cnt_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_s_q   <= in_s;
        s1_e_q   <= in_e;
        s1_m_q   <= algn_m;
        s1_cnt_q <= algn_cnt;
      end
    end
  end

  logic [OW-1:0] kept, m_rnd;
  logic [W-1:0]  low_bits;
  logic          guard, sticky, carry;

  assign kept     = s1_m_q[W-1 -: OW];
  assign guard    = s1_m_q[W-1-OW];
  // Shifting out kept and guard leaves only the sticky bits
  assign low_bits = s1_m_q << (OW + 1);
  assign sticky   = |low_bits;

`ifdef FP_NORM_ROUND_EN
  logic [OW:0] sum;
  assign sum   = {1'b0, kept} + {{OW{1'b0}}, guard & (sticky | kept[0])};
  assign carry = sum[OW];
  assign m_rnd = carry ? {1'b1, {(OW-1){1'b0}}} : sum[OW-1:0];
`else
  assign carry = 1'b0;
  assign m_rnd = kept;
`endif

  // Two spare bits keep in_e - count + carry free of wraparound
  logic signed [EW+1:0] e_pre, e_fin;
  assign e_pre = $signed({2'b00, s1_e_q}) - $signed({{(EW+1-ORDER){1'b0}}, s1_cnt_q});
  assign e_fin = e_pre + $signed({{(EW+1){1'b0}}, carry});

  cls_e cls;

  // Classify: zero first, then underflow on the unrounded exponent, then overflow
  always_comb begin
    if (s1_cnt_q == (ORDER+1)'(W))
      cls = CLS_ZERO;
    else if (e_pre[EW+1] || (e_pre == '0))
      cls = CLS_UF;
    else if (e_fin >= $signed({2'b00, `FP_NORM_OF_EXP(EW)}))
      cls = CLS_OF;
    else
      cls = CLS_NORM;
  end

  // Build the S2 word for the chosen class
  always_comb begin
    s2_e_d     = '0;
    s2_m_d     = '0;
    s2_flags_d = '0;
    case (cls)
      CLS_ZERO: s2_flags_d[FLAG_ZERO] = 1'b1;
      CLS_UF: begin
        s2_flags_d[FLAG_UF] = 1'b1;
        s2_flags_d[FLAG_NX] = 1'b1;
      end
      CLS_OF: begin
        s2_e_d              = `FP_NORM_OF_EXP(EW);
        s2_flags_d[FLAG_OF] = 1'b1;
        s2_flags_d[FLAG_NX] = 1'b1;
      end
      default: begin
        s2_e_d              = e_fin[EW-1:0];
        s2_m_d              = m_rnd;
        s2_flags_d[FLAG_NX] = guard | sticky;
      end
    endcase
  end

  // S2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_s_q     <= 1'b0;
      s2_e_q     <= '0;
      s2_m_q     <= '0;
      s2_flags_q <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_s_q     <= s1_s_q;
        s2_e_q     <= s2_e_d;
        s2_m_q     <= s2_m_d;
        s2_flags_q <= s2_flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_s     = s2_s_q;
  assign out_e     = s2_e_q;
  assign out_m     = s2_m_q;
  assign out_zero  = s2_flags_q[FLAG_ZERO];
  assign out_uf    = s2_flags_q[FLAG_UF];
  assign out_of    = s2_flags_q[FLAG_OF];
  assign out_nx    = s2_flags_q[FLAG_NX];

endmodule
